// File: rtl/line_rotation_pkg.sv
// Shared constants and state encoding for the line-rotation cut scheduler
// and its descrambler-side twin.
package line_rotation_pkg;
  localparam logic [15:0] LFSR_POLY        = 16'hB400;
  localparam logic [15:0] ZERO_KEY_SEED    = 16'hACE1;
  localparam int          ACTIVE_LINE_SIZE = 1440;
  localparam int          CUT_W            = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARM       = 2'd1,
    ST_RUN       = 2'd2,
    ST_SYNC_LOST = 2'd3
  } sched_state_t;

  // A zero key would lock the LFSR at zero, so it maps to a fixed non-zero seed.
  function automatic logic [15:0] seed_of(input logic [15:0] key);
    return (key == 16'h0000) ? ZERO_KEY_SEED : key;
  endfunction
endpackage

// File: rtl/scramble_lfsr_step.sv
// One step of the 16-bit Galois right-shift LFSR used to derive cut positions.
module scramble_lfsr_step
  import line_rotation_pkg::*;
#(
  parameter logic [15:0] POLY = LFSR_POLY
) (
  input  logic [15:0] i_lfsr,
  output logic [15:0] o_lfsr
);
  assign o_lfsr = (i_lfsr >> 1) ^ (i_lfsr[0] ? POLY : 16'h0000);
endmodule

// File: rtl/cut_position_scheduler.sv
// Per-line cut position generator: keyed LFSR sequenced by H/V/F timing,
// frame-aligned key changes and a line-period watchdog.
module cut_position_scheduler
  import line_rotation_pkg::*;
#(
  parameter logic [15:0] POLY          = LFSR_POLY,
  parameter int          MAX_LINE_CLKS = 2200,
  parameter int          LINE_CNT_BITS = 10
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     H,
  input  logic                     V,
  input  logic                     F,
  input  logic                     enable,
  input  logic [15:0]              key_in,
  input  logic                     key_valid,
  output logic                     key_ready,
  output logic [CUT_W-1:0]         raw_cut_position,
  output logic                     cut_valid,
  output logic [LINE_CNT_BITS-1:0] line_index,
  output logic                     sync_error
);
  localparam int                WD_W   = $clog2(MAX_LINE_CLKS + 1);
  localparam logic [WD_W-1:0]   WD_MAX = WD_W'(MAX_LINE_CLKS);

  sched_state_t             r_state, w_state_next;
  logic                     r_prev_h, r_prev_v;
  logic [15:0]              r_lfsr, w_lfsr_next;
  logic [CUT_W-1:0]         r_raw, w_raw_next;
  logic                     r_cut_valid, w_cut_valid_next;
  logic                     r_sync_error, w_sync_error_next;
  logic [LINE_CNT_BITS-1:0] r_line_index;
  logic [WD_W-1:0]          r_wd_cnt;
  logic                     r_key_pending, r_have_key;
  logic [15:0]              r_pending_key, r_active_key;

  logic        w_hr, w_hf, w_vf, w_frame_start, w_wd_hit, w_apply;
  logic [15:0] w_step, w_seed;

  assign w_hr          = ~r_prev_h & H;
  assign w_hf          = r_prev_h & ~H;
  assign w_vf          = r_prev_v & ~V;
  assign w_frame_start = w_vf & ~F;
  assign w_wd_hit      = (r_wd_cnt == WD_MAX);
  assign w_seed        = seed_of(r_key_pending ? r_pending_key : r_active_key);

  scramble_lfsr_step #(.POLY(POLY)) u_step (
    .i_lfsr (r_lfsr),
    .o_lfsr (w_step)
  );

  always_comb begin
    w_state_next      = r_state;
    w_lfsr_next       = r_lfsr;
    w_raw_next        = '0;
    w_cut_valid_next  = 1'b0;
    w_sync_error_next = r_sync_error;
    w_apply           = 1'b0;
    if (!enable) begin
      w_state_next = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (r_have_key || r_key_pending) w_state_next = ST_ARM;
        end
        ST_ARM, ST_SYNC_LOST: begin
          // A watchdog hit only matters while armed; SYNC_LOST waits for a frame start.
          if (r_state == ST_ARM && w_wd_hit) begin
            w_state_next      = ST_SYNC_LOST;
            w_sync_error_next = 1'b1;
          end else if (w_frame_start) begin
            w_state_next      = ST_RUN;
            w_lfsr_next       = w_seed;
            w_raw_next        = w_seed[CUT_W-1:0];
            w_cut_valid_next  = 1'b1;
            w_sync_error_next = 1'b0;
            w_apply           = 1'b1;
          end
        end
        ST_RUN: begin
          w_raw_next       = r_raw;
          w_cut_valid_next = 1'b1;
          if (w_wd_hit) begin
            w_state_next      = ST_SYNC_LOST;
            w_raw_next        = '0;
            w_cut_valid_next  = 1'b0;
            w_sync_error_next = 1'b1;
          end else if (w_frame_start) begin
            w_lfsr_next = w_seed;
            w_raw_next  = w_seed[CUT_W-1:0];
            w_apply     = 1'b1;
          end else if (w_vf || (w_hr && !V)) begin
            w_lfsr_next = w_step;
            w_raw_next  = w_step[CUT_W-1:0];
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_prev_h      <= 1'b1;
      r_prev_v      <= 1'b1;
      r_lfsr        <= ZERO_KEY_SEED;
      r_raw         <= '0;
      r_cut_valid   <= 1'b0;
      r_sync_error  <= 1'b0;
      r_line_index  <= '0;
      r_wd_cnt      <= '0;
      r_key_pending <= 1'b0;
      r_have_key    <= 1'b0;
      r_pending_key <= '0;
      r_active_key  <= '0;
    end else begin
      r_state      <= w_state_next;
      r_prev_h     <= H;
      r_prev_v     <= V;
      r_lfsr       <= w_lfsr_next;
      r_raw        <= w_raw_next;
      r_cut_valid  <= w_cut_valid_next;
      r_sync_error <= w_sync_error_next;

      if (w_hf)                r_wd_cnt <= '0;
      else if (!w_wd_hit)      r_wd_cnt <= r_wd_cnt + 1'b1;

      if (w_vf)                                   r_line_index <= '0;
      else if (w_hr && !V && (r_line_index != '1)) r_line_index <= r_line_index + 1'b1;

      // Apply and accept are mutually exclusive: accept needs no key pending.
      if (w_apply && r_key_pending) begin
        r_active_key  <= r_pending_key;
        r_have_key    <= 1'b1;
        r_key_pending <= 1'b0;
      end else if (key_valid && !r_key_pending) begin
        r_pending_key <= key_in;
        r_key_pending <= 1'b1;
      end
    end
  end

  assign key_ready        = ~r_key_pending;
  assign raw_cut_position = r_raw;
  assign cut_valid        = r_cut_valid;
  assign line_index       = r_line_index;
  assign sync_error       = r_sync_error;
endmodule

// File: tb/tb_cut_position_scheduler.sv
// Directed bench for cut_position_scheduler with hand-computed LFSR values.
module tb_cut_position_scheduler;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        H, V, F, enable, key_valid;
  logic [15:0] key_in;
  logic        key_ready, cut_valid, sync_error;
  logic [7:0]  raw_cut_position;
  logic [9:0]  line_index;
  int          checks = 0;
  int          errors = 0;
  int          n;

  cut_position_scheduler dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .H                (H),
    .V                (V),
    .F                (F),
    .enable           (enable),
    .key_in           (key_in),
    .key_valid        (key_valid),
    .key_ready        (key_ready),
    .raw_cut_position (raw_cut_position),
    .cut_valid        (cut_valid),
    .line_index       (line_index),
    .sync_error       (sync_error)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    reset_n = 1'b0; H = 1'b1; V = 1'b1; F = 1'b0;
    enable = 1'b0; key_valid = 1'b0; key_in = 16'h0000;
    step(); step();
    check("rst_raw", 32'(raw_cut_position), 32'h00);
    check("rst_cv", 32'(cut_valid), 32'd0);
    check("rst_krdy", 32'(key_ready), 32'd1);
    check("rst_serr", 32'(sync_error), 32'd0);
    check("rst_line", 32'(line_index), 32'd0);
    reset_n = 1'b1;
    step();

    // zero key -> ACE1 seed
    enable = 1'b1; key_in = 16'h0000; key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    check("k0_krdy_low", 32'(key_ready), 32'd0);
    step(); step();
    check("arm_raw", 32'(raw_cut_position), 32'h00);
    V = 1'b0;
    step();
    check("seed_raw", 32'(raw_cut_position), 32'hE1);
    check("seed_cv", 32'(cut_valid), 32'd1);
    check("seed_krdy", 32'(key_ready), 32'd1);
    check("seed_line", 32'(line_index), 32'd0);
    H = 1'b0; step();
    check("hf_stable", 32'(raw_cut_position), 32'hE1);
    H = 1'b1; step();
    check("hr1_raw", 32'(raw_cut_position), 32'h70);
    check("hr1_line", 32'(line_index), 32'd1);
    H = 1'b0; step();
    H = 1'b1; step();
    check("hr2_raw", 32'(raw_cut_position), 32'h38);
    check("hr2_line", 32'(line_index), 32'd2);

    // key 1234 accepted mid-field, deferred
    key_in = 16'h1234; key_valid = 1'b1; step();
    key_valid = 1'b0;
    check("k1_krdy_low", 32'(key_ready), 32'd0);
    H = 1'b0; step();
    H = 1'b1; step();
    check("defer_raw", 32'(raw_cut_position), 32'h9C);
    V = 1'b1; F = 1'b1; step();
    V = 1'b0; step();
    check("vf_f1_raw", 32'(raw_cut_position), 32'h4E);
    check("vf_f1_line", 32'(line_index), 32'd0);
    check("vf_f1_krdy", 32'(key_ready), 32'd0);
    H = 1'b0; step();
    H = 1'b1; step();
    check("f1_hr_raw", 32'(raw_cut_position), 32'h27);
    V = 1'b1; F = 1'b0; step();
    check("blank_raw", 32'(raw_cut_position), 32'h27);
    V = 1'b0; step();
    check("k1_seed_raw", 32'(raw_cut_position), 32'h34);
    check("k1_krdy_high", 32'(key_ready), 32'd1);

    // hr and vf in the same cycle
    H = 1'b0; step();
    H = 1'b1; step();
    check("k1_hr_raw", 32'(raw_cut_position), 32'h1A);
    H = 1'b0; step();
    V = 1'b1; step();
    H = 1'b1; V = 1'b0; step();
    check("coll_raw", 32'(raw_cut_position), 32'h34);
    check("coll_line", 32'(line_index), 32'd0);

    // enable toggle mid-line
    H = 1'b0; step();
    enable = 1'b0; step();
    check("dis_raw", 32'(raw_cut_position), 32'h00);
    check("dis_cv", 32'(cut_valid), 32'd0);
    enable = 1'b1; step(); step();
    check("rearm_raw", 32'(raw_cut_position), 32'h00);
    H = 1'b1; V = 1'b1; step();
    V = 1'b0; step();
    check("reen_raw", 32'(raw_cut_position), 32'h34);
    check("reen_cv", 32'(cut_valid), 32'd1);

    // watchdog: H held low
    H = 1'b0; step();
    n = 0;
    while (!sync_error && n < 2400) begin
      step();
      n++;
    end
    check("wd_cycles", 32'(n), 32'd2201);
    check("wd_serr", 32'(sync_error), 32'd1);
    check("wd_raw", 32'(raw_cut_position), 32'h00);
    check("wd_cv", 32'(cut_valid), 32'd0);
    H = 1'b1; step();
    H = 1'b0; step();
    check("sl_sticky", 32'(sync_error), 32'd1);
    check("sl_raw", 32'(raw_cut_position), 32'h00);
    H = 1'b1; V = 1'b1; step();
    V = 1'b0; step();
    check("rec_raw", 32'(raw_cut_position), 32'h34);
    check("rec_cv", 32'(cut_valid), 32'd1);
    check("rec_serr", 32'(sync_error), 32'd0);

    // asynchronous reset mid-field
    H = 1'b0; step();
    H = 1'b1; step();
    check("pre_rst_raw", 32'(raw_cut_position), 32'h1A);
    V = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    check("arst_raw", 32'(raw_cut_position), 32'h00);
    check("arst_cv", 32'(cut_valid), 32'd0);
    check("arst_krdy", 32'(key_ready), 32'd1);
    check("arst_line", 32'(line_index), 32'd0);
    step();
    reset_n = 1'b1;
    step(); step(); step();
    check("post_rst_raw", 32'(raw_cut_position), 32'h00);
    check("post_rst_cv", 32'(cut_valid), 32'd0);
    check("post_rst_line", 32'(line_index), 32'd0);
    check("post_rst_krdy", 32'(key_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
